id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: if_valid  input  1  fetch presents an instruction.
REQ-004 SHALL have port: if_instr  input  32  MIPS instruction word.
REQ-005 SHALL have port: id_ready  output  1  decode accepts if_instr this cycle (combinational).
REQ-006 SHALL have port: flush  input  1  synchronous kill of EX register and incoming instruction.
REQ-007 SHALL have port: ex_ready  input  1  downstream (RF/ALUControl/ALU) consumes EX register.
REQ-008 SHALL have port: ex_valid  output  1  EX register holds a real instruction.
REQ-009 SHALL have ports: ex_rs1, ex_rs2, ex_rd  output  5 each  register addresses for the RF.
REQ-010 SHALL have ports: ex_we, ex_memread, ex_alusrc  output  1 each  control bits.
REQ-011 SHALL have ports: ex_aluop  output  2, ex_func  output  6  ALUControl inputs.
REQ-012 SHALL have port: ex_imm  output  32  sign-extended immediate.
REQ-013 SHALL have ports: stall  output  1  load-use hazard this cycle; ill_instr  output  1  registered one-cycle pulse; bubble_cnt  output  8  saturating count of hazard bubbles.

Function
REQ-014 SHALL decode opcode=if_instr[31:26]; rs1=[25:21], rs2=[20:16], imm=sign-extend([15:0]).
REQ-015 R-type (000000) SHALL yield aluop=10, func=[5:0], rd=[15:11], we=1, memread=0, alusrc=0.
REQ-016 lw (100011) SHALL yield aluop=00, rd=[20:16], we=1, memread=1, alusrc=1, func=0.
REQ-017 sw (101011) SHALL yield aluop=00, rd=0, we=0, memread=0, alusrc=1, func=0.
REQ-018 beq (000100) SHALL yield aluop=01, rd=0, we=0, memread=0, alusrc=0, func=0.
REQ-019 addi (001000) SHALL yield aluop=00, rd=[20:16], we=1, memread=0, alusrc=1, func=0.
REQ-020 Any other opcode SHALL be accepted, load a bubble (ex_valid=0), and pulse ill_instr next cycle.
REQ-021 ex_we SHALL be forced 0 whenever decoded rd=0.
REQ-022 hazard SHALL be 1 when ex_valid & ex_memread & ex_rd!=0 and ex_rd equals a source read by the incoming instruction (R-type/sw/beq read rs1 and rs2; lw/addi read rs1 only) and if_valid=1.
REQ-023 stall SHALL equal hazard; id_ready SHALL be (!ex_valid | ex_ready) & !hazard & !flush.
REQ-024 EX register SHALL update only when !ex_valid | ex_ready; otherwise all ex_* hold unchanged.
REQ-025 On update: if if_valid & id_ready, load decoded fields (ex_valid=1 for legal opcodes); else load bubble (ex_valid=0, ex_we=0, ex_memread=0, other fields 0).
REQ-026 Hazard SHALL insert exactly one bubble: lw leaves on ex_ready, bubble loads, dependent instruction is accepted the following cycle.
REQ-027 bubble_cnt SHALL increment by 1 on each update cycle where hazard=1, saturating at 255.
REQ-028 flush SHALL take priority: next cycle ex_valid=0, ex_we=0, ex_memread=0, regardless of ex_ready; incoming instruction is dropped.
REQ-029 Latency SHALL be one cycle from acceptance to ex_valid=1 when no backpressure.

Reset
REQ-030 While rst_n=0, all outputs except id_ready/stall SHALL be 0 immediately (asynchronous); bubble_cnt=0.
REQ-031 Reset asserted mid-stall SHALL discard the held instruction; first edge after deassertion behaves as empty pipeline.

Verification
REQ-032 R-type add: if_instr=0x00221820, ex_ready=1 -> next cycle ex_valid=1, rs1=1, rs2=2, rd=3, aluop=10, func=100000, we=1.
REQ-033 Load-use: lw $5,4($1) (0x8C250004) then add $6,$5,$5 -> stall=1 one cycle, one bubble, bubble_cnt=1, add issued after.
REQ-034 Backpressure: ex_ready=0 with ex_valid=1 -> id_ready=0, all ex_* stable for 3 cycles; releases with original values.
REQ-035 Write to $0: add $0,$1,$2 -> ex_valid=1, ex_we=0; illegal opcode 0xFC000000 -> ex_valid=0, ill_instr pulse.
REQ-036 flush asserted with ex_ready=0 and ex_valid=1 -> next cycle ex_valid=0; rst_n pulse mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: MIPS instruction decode stage.
// Decodes the fetched word into RF addresses, ALU control and a sign-extended
// immediate, holds the result in a single EX register with valid/ready
// handshaking, and detects load-use hazards by inserting one bubble.
module id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    output logic        id_ready,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic        ex_we,
    output logic        ex_memread,
    output logic        ex_alusrc,
    output logic [1:0]  ex_aluop,
    output logic [5:0]  ex_func,
    output logic [31:0] ex_imm,
    output logic        stall,
    output logic        ill_instr,
    output logic [7:0]  bubble_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Instruction fields
    logic [5:0]  opcode;
    logic [4:0]  f_rs;
    logic [4:0]  f_rt;
    logic [4:0]  f_rd;
    logic [5:0]  f_func;
    logic [31:0] f_imm;

    assign opcode = if_instr[31:26];
    assign f_rs   = if_instr[25:21];
    assign f_rt   = if_instr[20:16];
    assign f_rd   = if_instr[15:11];
    assign f_func = if_instr[5:0];
    assign f_imm  = {{16{if_instr[15]}}, if_instr[15:0]};

    // Decoded control for the incoming instruction
    logic        dec_legal;
    logic        dec_reads_rs2;
    logic [4:0]  dec_rd;
    logic        dec_we;
    logic        dec_memread;
    logic        dec_alusrc;
    logic [1:0]  dec_aluop;
    logic [5:0]  dec_func;

    // EX register
    logic        ex_valid_q,   ex_valid_d;
    logic [4:0]  ex_rs1_q,     ex_rs1_d;
    logic [4:0]  ex_rs2_q,     ex_rs2_d;
    logic [4:0]  ex_rd_q,      ex_rd_d;
    logic        ex_we_q,      ex_we_d;
    logic        ex_memread_q, ex_memread_d;
    logic        ex_alusrc_q,  ex_alusrc_d;
    logic [1:0]  ex_aluop_q,   ex_aluop_d;
    logic [5:0]  ex_func_q,    ex_func_d;
    logic [31:0] ex_imm_q,     ex_imm_d;
    logic        ill_q,        ill_d;
    logic [7:0]  bubble_cnt_q, bubble_cnt_d;

    logic hazard;
    logic ex_upd;
    logic accept;

    // Opcode decode into ALU/RF control; unknown opcodes are flagged illegal
    always_comb begin
        dec_legal     = 1'b1;
        dec_reads_rs2 = 1'b0;
        dec_rd        = 5'd0;
        dec_we        = 1'b0;
        dec_memread   = 1'b0;
        dec_alusrc    = 1'b0;
        dec_aluop     = 2'b00;
        dec_func      = 6'd0;
        case (opcode)
            OP_RTYPE: begin
                dec_reads_rs2 = 1'b1;
                dec_rd        = f_rd;
                dec_we        = 1'b1;
                dec_aluop     = 2'b10;
                dec_func      = f_func;
            end
            OP_LW: begin
                dec_rd      = f_rt;
                dec_we      = 1'b1;
                dec_memread = 1'b1;
                dec_alusrc  = 1'b1;
            end
            OP_SW: begin
                dec_reads_rs2 = 1'b1;
                dec_alusrc    = 1'b1;
            end
            OP_BEQ: begin
                dec_reads_rs2 = 1'b1;
                dec_aluop     = 2'b01;
            end
            OP_ADDI: begin
                dec_rd     = f_rt;
                dec_we     = 1'b1;
                dec_alusrc = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
        // $0 is hardwired, so a write to it is never performed
        if (dec_rd == 5'd0) begin
            dec_we = 1'b0;
        end
    end

    // Load-use detection: a load in EX whose target feeds the incoming instruction
    always_comb begin
        hazard = 1'b0;
        if (if_valid && dec_legal && ex_valid_q && ex_memread_q && (ex_rd_q != 5'd0)) begin
            hazard = (ex_rd_q == f_rs) || (dec_reads_rs2 && (ex_rd_q == f_rt));
        end
    end

    assign ex_upd   = !ex_valid_q || ex_ready;
    assign stall    = hazard;
    assign id_ready = ex_upd && !hazard && !flush;
    assign accept   = if_valid && id_ready;

    // Next-state for the EX register: flush wins, otherwise load or bubble on update
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_rs1_d     = ex_rs1_q;
        ex_rs2_d     = ex_rs2_q;
        ex_rd_d      = ex_rd_q;
        ex_we_d      = ex_we_q;
        ex_memread_d = ex_memread_q;
        ex_alusrc_d  = ex_alusrc_q;
        ex_aluop_d   = ex_aluop_q;
        ex_func_d    = ex_func_q;
        ex_imm_d     = ex_imm_q;
        ill_d        = 1'b0;
        bubble_cnt_d = bubble_cnt_q;

        if (ex_upd && hazard && (bubble_cnt_q != 8'hFF)) begin
            bubble_cnt_d = bubble_cnt_q + 8'd1;
        end

        if (flush || ex_upd) begin
            ex_valid_d   = 1'b0;
            ex_rs1_d     = 5'd0;
            ex_rs2_d     = 5'd0;
            ex_rd_d      = 5'd0;
            ex_we_d      = 1'b0;
            ex_memread_d = 1'b0;
            ex_alusrc_d  = 1'b0;
            ex_aluop_d   = 2'b00;
            ex_func_d    = 6'd0;
            ex_imm_d     = 32'd0;
            if (accept) begin
                ill_d = !dec_legal;
                if (dec_legal) begin
                    ex_valid_d   = 1'b1;
                    ex_rs1_d     = f_rs;
                    ex_rs2_d     = f_rt;
                    ex_rd_d      = dec_rd;
                    ex_we_d      = dec_we;
                    ex_memread_d = dec_memread;
                    ex_alusrc_d  = dec_alusrc;
                    ex_aluop_d   = dec_aluop;
                    ex_func_d    = dec_func;
                    ex_imm_d     = f_imm;
                end
            end
        end
    end

    // EX register, illegal pulse and bubble counter; reset empties the pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_rs1_q     <= 5'd0;
            ex_rs2_q     <= 5'd0;
            ex_rd_q      <= 5'd0;
            ex_we_q      <= 1'b0;
            ex_memread_q <= 1'b0;
            ex_alusrc_q  <= 1'b0;
            ex_aluop_q   <= 2'b00;
            ex_func_q    <= 6'd0;
            ex_imm_q     <= 32'd0;
            ill_q        <= 1'b0;
            bubble_cnt_q <= 8'd0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_rs1_q     <= ex_rs1_d;
            ex_rs2_q     <= ex_rs2_d;
            ex_rd_q      <= ex_rd_d;
            ex_we_q      <= ex_we_d;
            ex_memread_q <= ex_memread_d;
            ex_alusrc_q  <= ex_alusrc_d;
            ex_aluop_q   <= ex_aluop_d;
            ex_func_q    <= ex_func_d;
            ex_imm_q     <= ex_imm_d;
            ill_q        <= ill_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_rs1     = ex_rs1_q;
    assign ex_rs2     = ex_rs2_q;
    assign ex_rd      = ex_rd_q;
    assign ex_we      = ex_we_q;
    assign ex_memread = ex_memread_q;
    assign ex_alusrc  = ex_alusrc_q;
    assign ex_aluop   = ex_aluop_q;
    assign ex_func    = ex_func_q;
    assign ex_imm     = ex_imm_q;
    assign ill_instr  = ill_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule
